// File: rtl/mul_share_sched.sv
// Round-robin scheduler sharing one registered W x W multiplier between NREQ requesters.
// Each issued operation is tagged with its requester id and returned after MUL_LAT+1 edges.
module mul_share_sched #(
    parameter int NREQ    = 4,
    parameter int W       = 2,
    parameter int MUL_LAT = 1,
    parameter int IDW     = $clog2(NREQ)
) (
    input  logic                CLK_0,
    input  logic                RST_0,
    input  logic                en,
    input  logic [NREQ-1:0]     req_mask,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*W-1:0]   req_a,
    input  logic [NREQ*W-1:0]   req_b,
    output logic [W-1:0]        mul_A,
    output logic [W-1:0]        mul_B,
    input  logic [2*W-1:0]      mul_P,
    output logic                rsp_valid,
    output logic [IDW-1:0]      rsp_id,
    output logic [2*W-1:0]      rsp_p,
    output logic                busy
);

    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  gnt_id;
    logic [NREQ-1:0] elig;
    logic [NREQ-1:0] gnt;
    logic            hs;
    logic [W-1:0]    sel_a;
    logic [W-1:0]    sel_b;
    logic [MUL_LAT:0] tag_v;
    logic [IDW-1:0]  tag_id [MUL_LAT+1];

    // Reset is folded into eligibility so no ready can appear during a reset cycle.
    assign elig = {NREQ{en & ~RST_0}} & ~req_mask & req_valid;

    always_comb begin
        int idx;
        idx    = 0;
        gnt    = '0;
        gnt_id = '0;
        hs     = 1'b0;
        for (int off = 1; off <= NREQ; off++) begin
            idx = (int'(ptr) + off) % NREQ;
            if (!hs && elig[idx]) begin
                gnt[idx] = 1'b1;
                gnt_id   = IDW'(idx);
                hs       = 1'b1;
            end
        end
    end

    assign req_ready = gnt;
    assign sel_a     = req_a[int'(gnt_id)*W +: W];
    assign sel_b     = req_b[int'(gnt_id)*W +: W];
    assign busy      = |tag_v;

    always_ff @(posedge CLK_0) begin
        if (RST_0) begin
            ptr       <= IDW'(NREQ-1);
            mul_A     <= '0;
            mul_B     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_p     <= '0;
            tag_v     <= '0;
            for (int i = 0; i <= MUL_LAT; i++) begin
                tag_id[i] <= '0;
            end
        end else begin
            if (hs) begin
                ptr <= gnt_id;
            end
            mul_A <= hs ? sel_a : '0;
            mul_B <= hs ? sel_b : '0;
            // Tag pipeline: the last stage lines up with the product on mul_P.
            for (int i = MUL_LAT; i > 0; i--) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end
            tag_v[0]  <= hs;
            tag_id[0] <= gnt_id;
            rsp_valid <= tag_v[MUL_LAT];
            if (tag_v[MUL_LAT]) begin
                rsp_p  <= mul_P;
                rsp_id <= tag_id[MUL_LAT];
            end
        end
    end

endmodule

// File: doc/mul_share_sched.md
Name: mul_share_sched

Overview:
- Round-robin scheduler that time-shares one registered W x W multiplier (the IP-integrator multiplier datapath, A/B in, P out) between NREQ requesters.
- Accepts operand pairs over per-requester valid/ready handshakes, issues up to one operation per cycle into the multiplier, and tags each one.
- Returns every product with the tag of the requester that issued it, after a fixed latency.
- Sits between requesting blocks and the multiplier wrapper inside the block design.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 2, operand width; product width is 2*W.
- MUL_LAT, 1, clock edges from the multiplier sampling mul_A/mul_B to the matching product on mul_P.
- IDW, clog2(NREQ) (2 at default), requester tag width.

Ports:
- CLK_0 in 1: single clock, all logic on the rising edge.
- RST_0 in 1: synchronous, active-high reset.
- en in 1: 1 = grants allowed; 0 = no new grants, in-flight operations drain.
- req_mask in NREQ: bit i = 1 disables requester i.
- req_valid in NREQ: requester i has an operand pair.
- req_ready out NREQ: one-hot grant; handshake i = req_valid[i] & req_ready[i] at a rising edge.
- req_a in NREQ*W: operand A of requester i in bits [i*W +: W].
- req_b in NREQ*W: operand B of requester i in bits [i*W +: W].
- mul_A out W: registered operand A to the multiplier.
- mul_B out W: registered operand B to the multiplier.
- mul_P in 2*W: product from the multiplier.
- rsp_valid out 1: one-cycle pulse, product available.
- rsp_id out IDW: tag of the requester that owns rsp_p.
- rsp_p out 2*W: registered product.
- busy out 1: high while any accepted operation has not yet produced its rsp_valid.

Behaviour:
- Reset values: req_ready=0, mul_A=0, mul_B=0, rsp_valid=0, rsp_id=0, rsp_p=0, busy=0, RR pointer=NREQ-1 (so requester 0 has top priority first), tag pipeline cleared.
- Eligible set: E[i] = en & ~RST_0 & ~req_mask[i] & req_valid[i].
- Grant: combinational. Pick the first set bit of E, searching from pointer+1 upward with wrap-around. req_ready is one-hot or all-zero. No requester may see ready without being eligible.
- Pointer update: on each handshake the pointer loads the granted index. With no handshake it holds.
- Issue, handshake at edge k:
  - Edge k loads mul_A/mul_B with the granted operands.
  - Edge k pushes {valid=1, id} into the tag shift register, depth MUL_LAT+1.
- No handshake at an edge: mul_A/mul_B load 0 and a {valid=0} entry is pushed.
- Response: the shift-register output is aligned with mul_P. At edge k+MUL_LAT+1, rsp_p <= mul_P, rsp_id <= tag id, rsp_valid <= tag valid.
  - rsp_valid is high for exactly one cycle per accepted operation.
  - rsp_p and rsp_id hold their value when rsp_valid=0.
  - Total latency is MUL_LAT+1 edges after the handshake edge (2 at default).
- Throughput: one issue per cycle sustained. Responses come back in issue order and have no backpressure.
- Arithmetic: unsigned. rsp_p is the full 2*W-bit product, no truncation (max 3*3=9 at W=2).
- Simultaneous events: an issue and a response in the same cycle are independent. Mask or en changes take effect on the grant in the same cycle, combinationally.
- en low with operations in flight: no grants; pending responses still complete; busy falls after the last rsp_valid.
- All requesters masked: behaves as en=0.
- Reset mid-operation: all in-flight tags are discarded and no rsp_valid is emitted for them. Outputs and pointer return to reset values at the reset edge. Requesters must re-present their data.
- busy = OR of the tag shift-register valid bits.

Test Plan:
- Single request: req_valid=0001, A0=2, B0=3 at edge k -> req_ready=0001 that cycle; mul_A=2, mul_B=3 after k; rsp_valid=1, rsp_id=0, rsp_p=6 after edge k+2; busy high after k through k+2.
- Full contention: all four valid continuously with (A,B)=(1,3),(2,3),(3,3),(2,2) -> grants 0,1,2,3,0,... on consecutive cycles; responses id 0,1,2,3 with p=3,6,9,4, one per cycle.
- Mask/en: req_mask=0010 with all valid -> grant order 0,2,3,0. Drop en after one issue -> no further req_ready; the pending response still arrives; busy returns to 0.
- Fairness after idle: grant to 2, idle 3 cycles, then requesters 0 and 3 valid -> 3 is granted before 0.
- Reset mid-flight: handshake at edge k, RST_0 high at edge k+1 -> no rsp_valid ever for that operation; all outputs 0; the next grant goes to requester 0.
- Boundary operands: A=3, B=3 -> rsp_p=9 (4'b1001). A=0, B=3 -> rsp_p=0 with rsp_valid still pulsed.
